// File: rtl/phase_freq_meter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : phase_freq_meter                                           |
// | Description : Recovers the phase increment of an NCO from its 8-bit      |
// |               phase stream by summing modulo-256 phase differences over  |
// |               2^WIN enabled samples and scaling the sum to phinc units.  |
// |               Optional lock detector enabled by PFM_LOCK_DETECT_EN.      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module phase_freq_meter #(
   parameter int m   = 28,
   parameter int WIN = 20,
   parameter int TOL = 1
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       en,
   input  logic [7:0] phase_in,
   output logic [7:0] phinc_est,
   output logic       est_valid,
   output logic       locked
);

   // Scaling shift from window-averaged phase steps to accumulator phinc units
   localparam int SH = m - 8 - WIN;
   // Sum of 2^WIN differences of at most 255 each always fits in WIN+8 bits
   localparam int SW = WIN + 8;

   if (WIN < 1 || WIN > m - 8 || TOL < 0) begin : g_param_check
      $error("phase_freq_meter: WIN must be in 1..m-8 and TOL must be >= 0");
   end

   logic [7:0]    prev_phase;
   logic          have_prev;
   logic [SW-1:0] sum;
   logic [SW-1:0] sum_final;
   logic [WIN-1:0] cnt;
   logic          close_pend;

   logic [7:0]    diff;
   logic [SW-1:0] sum_next;
   logic [m-1:0]  scaled;
   logic [7:0]    est_sat;

   // Modulo-256 subtraction: wraps such as 250->4 naturally give a positive step
   assign diff     = phase_in - prev_phase;
   assign sum_next = sum + {{WIN{1'b0}}, diff};
   assign scaled   = m'(sum_final) << SH;
   assign est_sat  = (|scaled[m-1:8]) ? 8'hFF : scaled[7:0];

   // Window accumulation, window close and registered estimate output
   always_ff @(posedge clk) begin
      if (!clrn) begin
         prev_phase <= 8'd0;
         have_prev  <= 1'b0;
         sum        <= '0;
         sum_final  <= '0;
         cnt        <= '0;
         close_pend <= 1'b0;
         phinc_est  <= 8'd0;
         est_valid  <= 1'b0;
      end else begin
         est_valid  <= close_pend;
         close_pend <= 1'b0;
         if (close_pend) begin
            phinc_est <= est_sat;
         end
         if (en) begin
            prev_phase <= phase_in;
            if (!have_prev) begin
               // First sample after reset only primes the difference history
               have_prev <= 1'b1;
            end else if (&cnt) begin
               // This sample supplies the last difference of the window
               sum_final  <= sum_next;
               close_pend <= 1'b1;
               sum        <= '0;
               cnt        <= '0;
            end else begin
               sum <= sum_next;
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

`ifdef PFM_LOCK_DETECT_EN
   typedef enum logic [1:0] {
      ACQ    = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } lock_state_t;

   lock_state_t state;
   logic [7:0]  last_est;
   logic [7:0]  delta;
   logic        within;

   assign delta  = (phinc_est >= last_est) ? (phinc_est - last_est) : (last_est - phinc_est);
   assign within = (32'(delta) <= 32'(TOL));

   // Lock FSM advances only when a fresh estimate is presented
   always_ff @(posedge clk) begin
      if (!clrn) begin
         state    <= ACQ;
         last_est <= 8'd0;
         locked   <= 1'b0;
      end else if (est_valid) begin
         last_est <= phinc_est;
         case (state)
            ACQ: begin
               state  <= CHECK;
               locked <= 1'b0;
            end
            CHECK: begin
               if (within) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
               end
            end
            LOCKED: begin
               if (!within) begin
                  state  <= CHECK;
                  locked <= 1'b0;
               end
            end
            default: begin
               state  <= ACQ;
               locked <= 1'b0;
            end
         endcase
      end
   end
`else
   assign locked = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_phase_freq_meter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_phase_freq_meter                                        |
// | Description : Directed self-checking bench for phase_freq_meter with a   |
// |               12-bit reference accumulator driving the phase stream.     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_phase_freq_meter;

   logic       clk = 1'b0;
   logic       clrn = 1'b0;
   logic       en = 1'b0;
   logic       en2 = 1'b0;
   logic [7:0] phase_in = 8'd0;
   logic [7:0] phase2 = 8'd0;
   logic [7:0] phinc_est, est2;
   logic       est_valid, valid2, locked, locked2;

   int checks = 0;
   int errors = 0;

   logic [11:0] acc = 12'd0;
   logic [11:0] phinc = 12'd0;
   logic [7:0]  ph2 = 8'd0;
   bit          tog = 1'b0;
   int          since = 0;
   int          gap = 0;
   int          pulses = 0;

   always #5 clk = ~clk;

   phase_freq_meter #(.m(12), .WIN(4), .TOL(1)) dut (
      .clk       (clk),
      .clrn      (clrn),
      .en        (en),
      .phase_in  (phase_in),
      .phinc_est (phinc_est),
      .est_valid (est_valid),
      .locked    (locked)
   );

   phase_freq_meter #(.m(12), .WIN(3), .TOL(1)) dut_sat (
      .clk       (clk),
      .clrn      (clrn),
      .en        (en2),
      .phase_in  (phase2),
      .phinc_est (est2),
      .est_valid (valid2),
      .locked    (locked2)
   );

   // Expected lock level: only meaningful when the detector is built in
   function automatic logic lk(input logic v);
`ifdef PFM_LOCK_DETECT_EN
      return v;
`else
      return 1'b0 & v;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock on the main DUT; the accumulator advances only on enabled samples
   task automatic step(input logic e);
      en       = e;
      phase_in = acc[11:4];
      if (e) acc = acc + phinc;
      @(posedge clk);
      #1;
      since++;
      if (est_valid === 1'b1) begin
         gap   = since;
         since = 0;
         pulses++;
      end
   endtask

   task automatic do_reset();
      clrn = 1'b0;
      step(1'b0);
      clrn  = 1'b1;
      acc   = 12'd0;
      since = 0;
   endtask

   // Run until the next estimate pulse (bounded), then check spacing and value
   task automatic wait_pulse(input string tag, input bit toggle, input int exp_gap,
                             input logic [7:0] exp_est);
      int p0;
      int n;
      p0 = pulses;
      n  = 0;
      while (pulses == p0 && n < 100) begin
         if (toggle) begin
            step(tog);
            tog = ~tog;
         end else begin
            step(1'b1);
         end
         n++;
      end
      check({tag, " pulse seen"}, pulses, p0 + 1);
      if (pulses != p0) begin
         if (exp_gap > 0) check({tag, " gap"}, gap, exp_gap);
         check({tag, " est"}, phinc_est, exp_est);
      end
   endtask

   // One clock on the saturation DUT; inc is the step applied before the next sample
   task automatic step2(input logic e, input logic [7:0] inc);
      en2    = e;
      phase2 = ph2;
      @(posedge clk);
      #1;
      if (e) ph2 = ph2 + inc;
   endtask

   initial begin
      // Reset state
      clrn = 1'b0;
      step(1'b0);
      step(1'b0);
      check("rst phinc_est", phinc_est, 8'h00);
      check("rst est_valid", est_valid, 1'b0);
      check("rst locked", locked, 1'b0);
      check("rst sat est", est2, 8'h00);
      check("rst sat valid", valid2, 1'b0);

      // Continuous enable, phinc 0x30: prime + 16 diffs, then every 16 clocks
      clrn  = 1'b1;
      acc   = 12'd0;
      since = 0;
      phinc = 12'h030;
      wait_pulse("cont1", 1'b0, 18, 8'h30);
      step(1'b1);
      check("cont1 single pulse", est_valid, 1'b0);
      check("lock after est1", locked, lk(1'b0));
      wait_pulse("cont2", 1'b0, 16, 8'h30);
      step(1'b1);
      check("lock after est2", locked, lk(1'b1));
      check("est hold", phinc_est, 8'h30);

      // Enable toggling: same estimate, pulses 32 clocks apart
      tog = 1'b0;
      wait_pulse("tog1", 1'b1, 0, 8'h30);
      wait_pulse("tog2", 1'b1, 32, 8'h30);

      // Wrapping phase stream, phinc 0xF0
      do_reset();
      phinc = 12'h0F0;
      wait_pulse("wrap1", 1'b0, 18, 8'hF0);
      wait_pulse("wrap2", 1'b0, 16, 8'hF0);

      // Reset after 9 samples discards the partial window
      do_reset();
      phinc = 12'h050;
      repeat (9) step(1'b1);
      clrn = 1'b0;
      step(1'b1);
      check("midrst phinc_est", phinc_est, 8'h00);
      check("midrst est_valid", est_valid, 1'b0);
      clrn  = 1'b1;
      acc   = 12'd0;
      since = 0;
      phinc = 12'h030;
      wait_pulse("post midrst", 1'b0, 18, 8'h30);

      // Reset in the cycle after the closing sample suppresses the pulse
      do_reset();
      phinc = 12'h030;
      repeat (17) step(1'b1);
      clrn = 1'b0;
      step(1'b0);
      check("valid in reset", est_valid, 1'b0);
      check("est in reset", phinc_est, 8'h00);
      clrn = 1'b1;
      step(1'b0);
      check("valid after reset", est_valid, 1'b0);

      // Lock tracking across a frequency change 0x30 -> 0x50
      do_reset();
      phinc = 12'h030;
      wait_pulse("lk1", 1'b0, 18, 8'h30);
      wait_pulse("lk2", 1'b0, 16, 8'h30);
      step(1'b1);
      check("lk locked 0x30", locked, lk(1'b1));
      phinc = 12'h050;
      // Window holds 3 diffs of 3 and 13 diffs of 5 -> 0x4A
      wait_pulse("lk3", 1'b0, 16, 8'h4A);
      step(1'b1);
      check("lk lost on change", locked, lk(1'b0));
      wait_pulse("lk4", 1'b0, 16, 8'h50);
      step(1'b1);
      check("lk still checking", locked, lk(1'b0));
      wait_pulse("lk5", 1'b0, 16, 8'h50);
      step(1'b1);
      check("lk relocked 0x50", locked, lk(1'b1));

      // Saturation on WIN=3 instance: 8 x 0x0F -> 0xF0, then 8 x 0x11 -> 0x110 -> 0xFF
      en = 1'b0;
      do_reset();
      ph2 = 8'h10;
      for (int i = 1; i <= 9; i++) begin
         step2(1'b1, (i == 9) ? 8'h11 : 8'h0F);
      end
      check("sat latency", valid2, 1'b0);
      step2(1'b1, 8'h11);
      check("sat win1 valid", valid2, 1'b1);
      check("sat win1 est", est2, 8'hF0);
      for (int i = 11; i <= 17; i++) begin
         step2(1'b1, 8'h11);
      end
      step2(1'b0, 8'h00);
      check("sat win2 valid", valid2, 1'b1);
      check("sat win2 est", est2, 8'hFF);
      step2(1'b0, 8'h00);
      check("sat pulse end", valid2, 1'b0);
      check("sat est hold", est2, 8'hFF);
      check("sat locked idle", locked2, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
